// File: rtl/keyboard_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : keyboard_decoder
//  Purpose  : PS/2 keyboard receiver. Synchronises and de-glitches the PS/2
//             lines, assembles 11-bit frames, checks parity and stop bit, and
//             turns make/break scan codes into one-cycle game action strobes.
//  Revision : 1.0  initial release
// ============================================================================
module keyboard_decoder #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic [2:0] keyboard_data,
   output logic       keyboard_locker
);

   localparam int FILT_W = (FILTER_LEN > 1)     ? $clog2(FILTER_LEN)     : 1;
   localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------------
   logic [1:0]        clk_sync_q;
   logic [1:0]        dat_sync_q;
   logic              filt_q,  filt_d;
   logic [FILT_W-1:0] fcnt_q,  fcnt_d;
   logic              ps2_fall_w;
   logic              ps2_bit_w;

   state_t            state_q, state_d;
   logic [3:0]        bitcnt_q, bitcnt_d;
   logic [9:0]        shift_q, shift_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              byte_vld_w;
   logic [7:0]        byte_w;

   logic              ext_q, ext_d;
   logic              brk_q, brk_d;
   logic [6:0]        held_q, held_d;
   logic [2:0]        data_q, data_d;
   logic              locker_q, locker_d;
   logic [3:0]        map_w;

   // Translate a scan code into {hit, action}; aliases share one action.
   function automatic logic [3:0] map_key(input logic ext, input logic [7:0] code);
      logic [3:0] res;
      res = 4'b0000;
      case (code)
         8'h75:   res = ext ? 4'b1_000 : 4'b0_000;
         8'h72:   res = ext ? 4'b1_001 : 4'b0_000;
         8'h6B:   res = ext ? 4'b1_010 : 4'b0_000;
         8'h74:   res = ext ? 4'b1_011 : 4'b0_000;
         8'h1D:   res = 4'b1_000;
         8'h1B:   res = 4'b1_001;
         8'h1C:   res = 4'b1_010;
         8'h23:   res = 4'b1_011;
         8'h29:   res = 4'b1_100;
         8'h1A:   res = 4'b1_101;
         8'h5A:   res = ext ? 4'b0_000 : 4'b1_110;
         default: res = 4'b0_000;
      endcase
      return res;
   endfunction

   // Two-flop synchronisers for both asynchronous PS/2 lines (idle high).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clock};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
      end
   end

   // Glitch filter: accept a new clock level only after FILTER_LEN equal samples.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (fcnt_q == FILT_W'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q[1];
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   // Filter state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 1'b1;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign ps2_fall_w = filt_q & ~filt_d;
   assign ps2_bit_w  = dat_sync_q[1];

   // Frame receiver next-state: start bit, 8 data LSB first, parity, stop.
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      tmo_d      = tmo_q;
      byte_vld_w = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tmo_d    = '0;
            bitcnt_d = '0;
            if (ps2_fall_w && !ps2_bit_w) begin
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            if (ps2_fall_w) begin
               tmo_d   = '0;
               shift_d = {ps2_bit_w, shift_q[9:1]};
               if (bitcnt_q == 4'd9) begin
                  state_d  = ST_CHECK;
                  bitcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               // Keyboard went quiet mid-frame: drop the partial frame.
               state_d  = ST_IDLE;
               tmo_d    = '0;
               bitcnt_d = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_CHECK: begin
            state_d    = ST_IDLE;
            byte_vld_w = shift_q[9] & (^shift_q[8:0]);
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign byte_w = shift_q[7:0];

   // Frame receiver state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         tmo_q    <= tmo_d;
      end
   end

   // Scan-code decoder: prefix flags, held-key mask and action strobe.
   always_comb begin
      ext_d    = ext_q;
      brk_d    = brk_q;
      held_d   = held_q;
      data_d   = data_q;
      locker_d = 1'b0;
      map_w    = map_key(ext_q, byte_w);
      if (byte_vld_w) begin
         if (byte_w == 8'hE0) begin
            ext_d = 1'b1;
         end else if (byte_w == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (map_w[3]) begin
               if (brk_q) begin
                  held_d[map_w[2:0]] = 1'b0;
               end else if (!held_q[map_w[2:0]]) begin
                  // First make of this action; repeats while held are dropped.
                  held_d[map_w[2:0]] = 1'b1;
                  data_d             = map_w[2:0];
                  locker_d           = 1'b1;
               end
            end
         end
      end
   end

   // Decoder state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         held_q   <= '0;
         data_q   <= '0;
         locker_q <= 1'b0;
      end else begin
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         held_q   <= held_d;
         data_q   <= data_d;
         locker_q <= locker_d;
      end
   end

   assign keyboard_data   = data_q;
   assign keyboard_locker = locker_q;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_keyboard_decoder
//  Purpose  : Self-checking bench for keyboard_decoder. PS/2 frames are
//             driven bit by bit; strobes are collected and compared against a
//             scan-code level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keyboard_decoder;

   localparam int FILTER_LEN     = 4;
   localparam int TIMEOUT_CYCLES = 300;
   localparam int HALF           = 12;
   // Posedges from the raw stop-bit falling edge to the strobe:
   // 2 synchroniser + FILTER_LEN filter samples (stop bit taken) + CHECK/decode.
   localparam int LAT            = 2 + FILTER_LEN + 1;

   logic       clock     = 1'b0;
   logic       reset_n   = 1'b0;
   logic       ps2_clock = 1'b1;
   logic       ps2_data  = 1'b1;
   logic [2:0] keyboard_data;
   logic       keyboard_locker;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   keyboard_decoder #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ps2_clock      (ps2_clock),
      .ps2_data       (ps2_data),
      .keyboard_data  (keyboard_data),
      .keyboard_locker(keyboard_locker)
   );

   // Strobe collector; a strobe longer than one cycle is an error.
   logic [2:0] strobes[$];
   logic       prev_lock = 1'b0;
   always @(posedge clock) begin
      #1;
      if (keyboard_locker === 1'b1) begin
         strobes.push_back(keyboard_data);
         n_cmp++;
         if (prev_lock) begin
            n_err++;
            $display("FAIL strobe_width: locker high %0d consecutive cycles, required 1", 2);
         end
      end
      prev_lock = keyboard_locker;
   end

   // ---------------- reference model (scan-code level) ----------------
   bit         m_ext, m_brk;
   bit   [6:0] m_held;
   logic [2:0] m_data;
   logic [2:0] exp_q[$];

   function automatic int model_map(input bit ext, input logic [7:0] b);
      case (b)
         8'h1D: return 0;
         8'h1B: return 1;
         8'h1C: return 2;
         8'h23: return 3;
         8'h29: return 4;
         8'h1A: return 5;
         8'h5A: return ext ? -1 : 6;
         8'h75: return ext ? 0 : -1;
         8'h72: return ext ? 1 : -1;
         8'h6B: return ext ? 2 : -1;
         8'h74: return ext ? 3 : -1;
         default: return -1;
      endcase
   endfunction

   function automatic void model_reset();
      m_ext = 0; m_brk = 0; m_held = '0; m_data = 3'd0;
      exp_q.delete();
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int a;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         a = model_map(m_ext, b);
         if (a >= 0) begin
            if (m_brk) m_held[a] = 1'b0;
            else if (!m_held[a]) begin
               m_held[a] = 1'b1;
               m_data    = 3'(a);
               exp_q.push_back(3'(a));
            end
         end
         m_ext = 0; m_brk = 0;
      end
   endfunction

   // ---------------- PS/2 stimulus ----------------
   task automatic ps2_bit(input logic b, input bit glitch);
      int w;
      w = $urandom_range(1, FILTER_LEN - 1);
      @(negedge clock);
      ps2_data = b;
      repeat (HALF / 2) @(negedge clock);
      if (glitch) begin
         ps2_clock = 1'b0;
         repeat (w) @(negedge clock);
         ps2_clock = 1'b1;
      end
      repeat (HALF - HALF / 2) @(negedge clock);
      ps2_clock = 1'b0;
      repeat (HALF / 2) @(negedge clock);
      if (glitch) begin
         ps2_clock = 1'b1;
         repeat (w) @(negedge clock);
         ps2_clock = 1'b0;
      end
      repeat (HALF - HALF / 2) @(negedge clock);
      ps2_clock = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
      logic par;
      par = (~^b) ^ bad_par;
      ps2_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
      ps2_bit(par, glitch);
      ps2_bit(1'b1, glitch);
      @(negedge clock);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      ps2_clock = 1'b1;
      ps2_data  = 1'b1;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      model_reset();
      strobes.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (keyboard_data !== 3'd0) begin
         n_err++; $display("FAIL reset_data: got %0d, required 0", keyboard_data);
      end
      n_cmp++;
      if (keyboard_locker !== 1'b0) begin
         n_err++; $display("FAIL reset_locker: got %b, required 0", keyboard_locker);
      end
      reset_n = 1'b1;
      model_reset();
      strobes.delete();
      repeat (30) @(negedge clock);
      n_cmp++;
      if (strobes.size() != 0) begin
         n_err++; $display("FAIL reset_idle_strobes: got %0d, required 0", strobes.size());
      end
   endtask

   task automatic test_latency();
      logic [7:0] b;
      int first_hi, hi_cnt;
      logic [2:0] seen;
      b = 8'h1D;
      do_reset();
      ps2_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
      ps2_bit(~^b, 0);
      @(negedge clock);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clock);
      ps2_clock = 1'b0;
      first_hi = -1; hi_cnt = 0; seen = 3'd7;
      for (int k = 1; k <= HALF - 1; k++) begin
         @(posedge clock); #1;
         if (keyboard_locker === 1'b1) begin
            hi_cnt++;
            if (first_hi < 0) begin first_hi = k; seen = keyboard_data; end
         end
      end
      @(negedge clock);
      ps2_clock = 1'b1;
      repeat (HALF) @(negedge clock);
      n_cmp++;
      if (first_hi != LAT) begin
         n_err++; $display("FAIL latency: strobe at edge %0d, required %0d", first_hi, LAT);
      end
      n_cmp++;
      if (hi_cnt != 1) begin
         n_err++; $display("FAIL latency_width: high %0d cycles, required 1", hi_cnt);
      end
      n_cmp++;
      if (seen !== 3'd0) begin
         n_err++; $display("FAIL latency_data: got %0d, required 0", seen);
      end
   endtask

   task automatic test_typematic();
      logic [7:0] seq [9];
      seq = '{8'hE0, 8'h74, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74, 8'hE0, 8'h74};
      do_reset();
      foreach (seq[i]) begin
         send_frame(seq[i], 0, 0);
         model_byte(seq[i]);
      end
      n_cmp++;
      if (strobes.size() != 2 || exp_q.size() != 2) begin
         n_err++; $display("FAIL typematic_count: got %0d, required 2", strobes.size());
      end
      foreach (strobes[i]) begin
         n_cmp++;
         if (strobes[i] !== 3'd3) begin
            n_err++; $display("FAIL typematic_data[%0d]: got %0d, required 3", i, strobes[i]);
         end
      end
   endtask

   task automatic test_parity();
      do_reset();
      send_frame(8'h5A, 0, 0); model_byte(8'h5A);
      send_frame(8'h29, 1, 0);
      n_cmp++;
      if (strobes.size() != 1 || keyboard_data !== 3'd6) begin
         n_err++; $display("FAIL parity_drop: strobes %0d data %0d, required 1 and 6",
                           strobes.size(), keyboard_data);
      end
      send_frame(8'h29, 0, 0); model_byte(8'h29);
      n_cmp++;
      if (strobes.size() != 2 || keyboard_data !== 3'd4) begin
         n_err++; $display("FAIL parity_recover: strobes %0d data %0d, required 2 and 4",
                           strobes.size(), keyboard_data);
      end
      // A corrupted byte after F0 must not consume the break prefix.
      send_frame(8'hF0, 0, 0); model_byte(8'hF0);
      send_frame(8'h29, 1, 0);
      send_frame(8'h5A, 0, 0); model_byte(8'h5A);
      send_frame(8'h5A, 0, 0); model_byte(8'h5A);
      n_cmp++;
      if (strobes.size() != exp_q.size() || strobes.size() != 3) begin
         n_err++; $display("FAIL parity_flags: strobes %0d, required %0d", strobes.size(), exp_q.size());
      end else if (strobes[2] !== 3'd6) begin
         n_err++; $display("FAIL parity_flags_data: got %0d, required 6", strobes[2]);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b;
      b = 8'h5A;
      do_reset();
      ps2_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) ps2_bit(b[i], 0);
      repeat (TIMEOUT_CYCLES + 1) @(negedge clock);
      send_frame(8'h5A, 0, 0); model_byte(8'h5A);
      n_cmp++;
      if (strobes.size() != 1) begin
         n_err++; $display("FAIL timeout_count: got %0d, required 1", strobes.size());
      end else begin
         n_cmp++;
         if (strobes[0] !== 3'd6) begin
            n_err++; $display("FAIL timeout_data: got %0d, required 6", strobes[0]);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      send_frame(8'h1A, 0, 1); model_byte(8'h1A);
      n_cmp++;
      if (strobes.size() != 1) begin
         n_err++; $display("FAIL glitch_count: got %0d, required 1", strobes.size());
      end else begin
         n_cmp++;
         if (strobes[0] !== 3'd5) begin
            n_err++; $display("FAIL glitch_data: got %0d, required 5", strobes[0]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      b = 8'h1B;
      do_reset();
      send_frame(8'h5A, 0, 0);
      ps2_bit(1'b0, 0);
      for (int i = 0; i < 5; i++) ps2_bit(b[i], 0);
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (keyboard_data !== 3'd0 || keyboard_locker !== 1'b0) begin
         n_err++; $display("FAIL midreset_outputs: data %0d locker %b, required 0 0",
                           keyboard_data, keyboard_locker);
      end
      reset_n = 1'b1;
      model_reset();
      strobes.delete();
      repeat (3 * HALF) @(negedge clock);
      n_cmp++;
      if (strobes.size() != 0) begin
         n_err++; $display("FAIL midreset_spurious: got %0d strobes, required 0", strobes.size());
      end
      send_frame(8'h1B, 0, 0); model_byte(8'h1B);
      n_cmp++;
      if (strobes.size() != 1 || keyboard_data !== 3'd1) begin
         n_err++; $display("FAIL midreset_recover: strobes %0d data %0d, required 1 and 1",
                           strobes.size(), keyboard_data);
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [12];
      logic [7:0] fr[$];
      logic [7:0] code;
      int idx, bad;
      pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h1A, 8'h5A,
               8'h75, 8'h72, 8'h6B, 8'h74, 8'h15};
      do_reset();
      for (int n = 0; n < 24; n++) begin
         fr.delete();
         idx  = $urandom_range(0, 11);
         code = pool[idx];
         if ((idx >= 7 && idx <= 10) ||
             ((code == 8'h5A || code == 8'h15) && $urandom_range(0, 3) == 0))
            fr.push_back(8'hE0);
         if ($urandom_range(0, 9) < 4) fr.push_back(8'hF0);
         fr.push_back(code);
         bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, fr.size() - 1) : -1;
         foreach (fr[i]) begin
            send_frame(fr[i], (i == bad), 0);
            if (i != bad) model_byte(fr[i]);
         end
         repeat ($urandom_range(0, 20)) @(negedge clock);
      end
      n_cmp++;
      if (strobes.size() != exp_q.size()) begin
         n_err++; $display("FAIL random_count: got %0d, required %0d", strobes.size(), exp_q.size());
      end
      for (int i = 0; i < strobes.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (strobes[i] !== exp_q[i]) begin
            n_err++; $display("FAIL random_data[%0d]: got %0d, required %0d", i, strobes[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (keyboard_data !== m_data) begin
         n_err++; $display("FAIL random_hold: got %0d, required %0d", keyboard_data, m_data);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_typematic();
      test_parity();
      test_timeout();
      test_glitch();
      test_reset_midframe();
      test_random();
      repeat (5) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keyboard_decoder.md
KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive identical synchronized samples needed to accept a new PS/2 clock level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clock cycles with no accepted PS/2 falling edge before a partial frame is discarded.
REQ-003 Port clock, input, 1: system clock; all state on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port ps2_clock, input, 1: raw PS/2 clock line, asynchronous to clock.
REQ-006 Port ps2_data, input, 1: raw PS/2 data line, asynchronous to clock.
REQ-007 Port keyboard_data, output, 3: action code of the most recent accepted key press.
REQ-008 Port keyboard_locker, output, 1: one-cycle strobe marking keyboard_data as new; consumed by the game-logic stage.

Function
REQ-009 ps2_clock and ps2_data SHALL each pass a 2-flop synchronizer before any other use.
REQ-010 Filtered PS/2 clock SHALL change level only after FILTER_LEN consecutive equal synchronized samples; filtered reset level 1.
REQ-011 A falling edge of the filtered PS/2 clock SHALL sample synchronized ps2_data as the next frame bit.
REQ-012 Frame receiver FSM states: IDLE, RECV, CHECK.
REQ-013 IDLE: sampled 0 -> RECV, bit count 0; sampled 1 -> stay IDLE, nothing recorded.
REQ-014 RECV: shift in 8 data bits LSB first, then parity, then stop; after the stop bit -> CHECK.
REQ-015 CHECK (one cycle): odd parity over 8 data bits + parity bit and stop = 1 -> emit the byte to the decoder; otherwise discard silently; either way -> IDLE.
REQ-016 In RECV, TIMEOUT_CYCLES cycles without a falling edge -> IDLE, partial frame discarded, no byte emitted; timeout counter cleared on every falling edge and in IDLE.
REQ-017 Decoder holds flags ext (E0 seen) and brk (F0 seen), both 0 after reset.
REQ-018 Byte E0 -> set ext; byte F0 -> set brk; neither produces output.
REQ-019 Any other byte -> translate (ext, byte) per REQ-020, apply REQ-021/022, then clear ext and brk in the same cycle.
REQ-020 Map: E0 75 or 1D -> 0 UP; E0 72 or 1B -> 1 DOWN; E0 6B or 1C -> 2 LEFT; E0 74 or 23 -> 3 RIGHT; 29 -> 4 SELECT; 1A -> 5 HALF; 5A (no E0) -> 6 CONFIRM; all other codes unmapped; code 7 never produced.
REQ-021 7-bit held mask, one bit per action, 0 after reset; break (brk = 1) of a mapped key clears its bit and produces no output.
REQ-022 Make of a mapped key with held bit 0 -> set bit, keyboard_data <= code, keyboard_locker = 1 for exactly the next cycle; held bit already 1 (typematic repeat) -> suppressed.
REQ-023 keyboard_data SHALL hold its value between strobes; unmapped bytes leave it unchanged.
REQ-024 Latency: keyboard_locker asserts exactly 2 clock cycles after the cycle the stop bit is sampled (CHECK, then decode register).
REQ-025 Aliased keys (e.g. W and E0 75) share one held bit; a second alias make while held is suppressed.
REQ-026 Parity error on the byte following F0 or E0 SHALL leave both flags unchanged.

Reset
REQ-027 reset_n low SHALL immediately force: FSM IDLE, bit count 0, timeout counter 0, ext = brk = 0, held mask 0, keyboard_data = 0, keyboard_locker = 0, synchronizer and filter flops 1.
REQ-028 reset_n asserted mid-frame SHALL discard the frame; no strobe after release until a complete new frame arrives.

Verification
REQ-029 Frame 0x1D valid parity -> keyboard_data = 0, keyboard_locker high exactly one cycle, 2 cycles after stop bit.
REQ-030 Sequence E0 74, E0 74, E0 F0 74, E0 74 -> exactly two strobes, both keyboard_data = 3.
REQ-031 Frame 0x29 with parity bit inverted -> no strobe, keyboard_data unchanged; following valid 0x29 -> strobe with 4.
REQ-032 Start bit + 4 data bits, then TIMEOUT_CYCLES+1 idle cycles, then full 0x5A frame -> one strobe with 6, no spurious byte.
REQ-033 1-cycle glitches on ps2_clock shorter than FILTER_LEN during a 0x1A frame -> exactly one strobe with 5.
REQ-034 reset_n pulsed low after bit 5 of 0x1B, then full 0x1B frame -> exactly one strobe with 1, all outputs 0 during reset.
